program_loader: RTL and testbench

- Writer side of the program memory. The control sequencer only fetches from RAM; this block fills RAM before a run.
- Accepts program bytes over a valid/ready stream and writes them to consecutive RAM addresses from 0.
- Reads the whole image back and checks an 8-bit modular checksum.
- Holds the CPU in reset until the check passes, then releases it.

---
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams program words into RAM from address 0, reads the image back and
// releases the CPU only when the write-side and read-side checksums agree.
module program_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, CHECK, RUN, ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              rd_vld_q;
  logic              cpu_clr_q, cpu_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wsum_d    = wsum_q;
    // Read data lands one cycle after its strobe, so accumulate on the delayed flag.
    rsum_d    = rd_vld_q ? rsum_q + ram_rdata : rsum_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    cpu_clr_d = cpu_clr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          wsum_d    = '0;
          rsum_d    = '0;
          cpu_clr_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = in_data;
          wsum_d  = wsum_q + in_data;
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d = VERIFY;
          cnt_d   = '0;
          re_d    = 1'b1;
          addr_d  = '0;
        end else begin
          state_d = LOAD;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      VERIFY: begin
        if (cnt_q == LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          re_d   = 1'b1;
          addr_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        busy_d = 1'b0;
        if (rsum_d == wsum_q) begin
          state_d   = RUN;
          cpu_clr_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_vld_q  <= 1'b0;
      cpu_clr_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_vld_q  <= re_q;
      cpu_clr_q <= cpu_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign ram_we    = we_q;
  assign ram_re    = re_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign cpu_clr   = cpu_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector tables per session plus
// hand-written reset, corruption and ignored-input sequences.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, ram_we, ram_re, cpu_clr, busy, done, error;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(16)) dut (
    .clk(clk), .clr(clr), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_clr(cpu_clr), .busy(busy), .done(done), .error(error)
  );

  // Synchronous RAM model; optional bit-0 flip on readback of address 3.
  logic [7:0] mem [16];
  logic       corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr] ^ ((corrupt && ram_addr == 4'd3) ? 8'h01 : 8'h00);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [3:0] we_a[$];
  logic [7:0] we_d[$];
  int         we_c[$];
  logic [3:0] re_a[$];
  int         overlap = 0;
  always @(negedge clk) begin
    if (ram_we) begin
      we_a.push_back(ram_addr);
      we_d.push_back(ram_wdata);
      we_c.push_back(cyc);
    end
    if (ram_re) re_a.push_back(ram_addr);
    if (ram_we && ram_re) overlap++;
  end

  typedef struct {
    logic [7:0] din;
    int         gap;
    logic [3:0] exp_addr;
    logic [7:0] exp_dat;
    int         exp_gap;
  } vec_t;
  vec_t vec[16];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    we_a.delete(); we_d.delete(); we_c.delete(); re_a.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_cpu_clr", cpu_clr, 1);
    chk("restart_done", done, 0);
    chk("restart_error", error, 0);
    chk("restart_busy", busy, 1);
    chk("restart_in_ready", in_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge where the word's ram_we is visible.
  task automatic send_word(input logic [7:0] d, input int idle);
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic run_session(input int n, input bit poke, output int lat);
    clear_logs();
    pulse_start();
    for (int i = 0; i < n; i++) send_word(vec[i].din, vec[i].gap);
    in_valid = poke;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (poke) start = (k == 3);
      if (done || error) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("we_count", we_a.size(), n);
    for (int i = 0; i < n && i < we_a.size(); i++) begin
      chk($sformatf("we_addr[%0d]", i), we_a[i], vec[i].exp_addr);
      chk($sformatf("we_data[%0d]", i), we_d[i], vec[i].exp_dat);
      if (i > 0) chk($sformatf("we_gap[%0d]", i), we_c[i] - we_c[i-1], vec[i].exp_gap);
    end
    chk("re_count", re_a.size(), 16);
    for (int i = 0; i < re_a.size() && i < 16; i++)
      chk($sformatf("re_addr[%0d]", i), re_a[i], i);
  endtask

  initial begin
    logic [7:0] bp_dat [16];
    int         bp_gap [16];
    int         bp_egap[16];
    int         lat, bad;
    logic [7:0] sum;

    bp_dat  = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h69, 8'h96,
                8'h11, 8'h22, 8'h44, 8'h88, 8'h77, 8'hEE, 8'hDD, 8'hBB};
    bp_gap  = '{0, 2, 1, 3, 0, 3, 2, 0, 1, 0, 3, 2, 0, 0, 2, 1};
    bp_egap = '{2, 3, 2, 4, 2, 4, 3, 2, 2, 2, 4, 3, 2, 2, 3, 2};

    // Reset state
    #2 clr = 1'b1;
    #1;
    chk("rst_cpu_clr", cpu_clr, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Idle with no start for 50 cycles
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_clr !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0 || ram_we !== 1'b0) bad++;
    end
    chk("idle_50_bad_cycles", bad, 0);
    chk("idle_no_writes", we_a.size(), 0);

    // Full load 0x00..0x0F back-to-back
    for (int i = 0; i < 16; i++) vec[i] = '{8'(i), 0, 4'(i), 8'(i), 2};
    run_session(16, 1'b0, lat);
    chk("full_done_lat", lat, 18);
    chk("full_done", done, 1);
    chk("full_cpu_clr", cpu_clr, 0);
    chk("full_busy", busy, 0);
    chk("full_error", error, 0);
    sum = 8'h00;
    foreach (we_d[i]) sum += we_d[i];
    chk("full_checksum", sum, 8'h78);

    // Gapped stream, restarted from RUN
    for (int i = 0; i < 16; i++) vec[i] = '{bp_dat[i], bp_gap[i], 4'(i), bp_dat[i], bp_egap[i]};
    run_session(16, 1'b0, lat);
    chk("bp_done", done, 1);
    chk("bp_cpu_clr", cpu_clr, 0);

    // start and in_valid during VERIFY are ignored
    for (int i = 0; i < 16; i++) vec[i] = '{8'(i), 0, 4'(i), 8'(i), 2};
    run_session(16, 1'b1, lat);
    chk("ign_done_lat", lat, 18);
    chk("ign_done", done, 1);
    chk("ign_busy", busy, 0);

    // Corrupt readback then clean retry
    corrupt = 1'b1;
    run_session(16, 1'b0, lat);
    chk("bad_lat", lat, 18);
    chk("bad_error", error, 1);
    chk("bad_cpu_clr", cpu_clr, 1);
    chk("bad_done", done, 0);
    chk("bad_busy", busy, 0);
    corrupt = 1'b0;
    run_session(16, 1'b0, lat);
    chk("retry_done", done, 1);
    chk("retry_error", error, 0);
    chk("retry_cpu_clr", cpu_clr, 0);

    // clr after 7 accepted words
    clear_logs();
    pulse_start();
    for (int i = 0; i < 7; i++) send_word(vec[i].din, 0);
    chk("mid_we_before_clr", ram_we, 1);
    clr = 1'b1;
    #1;
    chk("mid_ram_we", ram_we, 0);
    chk("mid_cpu_clr", cpu_clr, 1);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk) clr = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_in_ready", in_ready, 0);
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_cpu_clr", cpu_clr, 1);
    chk("mid_partial_writes", we_a.size(), 7);
    in_valid = 1'b0;
    run_session(16, 1'b0, lat);
    chk("mid_reload_done", done, 1);

    chk("we_re_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
